// File: rtl/mag_frame_tracker.sv
// Per-frame tracker behind the magnitude comparator: classifies each sample against the
// previous one and accumulates min/max and rise/fall counts into a valid/ready frame report.
module mag_frame_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             cmp_lt,
    output logic             cmp_eq,
    output logic             cmp_gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] frm_min,
    output logic [WIDTH-1:0] frm_max,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt
);

    localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [2:0] CMP_EQ = 3'b010;

    typedef enum logic [0:0] {ACCUM, REPORT} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [WIDTH-1:0]  prev_reg, prev_next;
    logic [2:0]        cmp_reg, cmp_next;
    logic [WIDTH-1:0]  min_reg, min_next;
    logic [WIDTH-1:0]  max_reg, max_next;
    logic [CNT_W-1:0]  rise_reg, rise_next;
    logic [CNT_W-1:0]  fall_reg, fall_next;
    logic              out_valid_reg, out_valid_next;
    logic              accept;
    logic              smp_gt, smp_lt;

    assign in_ready = ena & (state_reg == ACCUM);
    // clear has priority over a sample offered in the same cycle
    assign accept   = in_ready & in_valid & ~clear;
    assign smp_gt   = in_data > prev_reg;
    assign smp_lt   = in_data < prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            idx_reg       <= '0;
            prev_reg      <= '0;
            cmp_reg       <= CMP_EQ;
            min_reg       <= '0;
            max_reg       <= '0;
            rise_reg      <= '0;
            fall_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            prev_reg      <= prev_next;
            cmp_reg       <= cmp_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        prev_next      = prev_reg;
        cmp_next       = cmp_reg;
        min_next       = min_reg;
        max_next       = max_reg;
        rise_next      = rise_reg;
        fall_next      = fall_reg;
        out_valid_next = out_valid_reg;

        if (ena) begin
            if (clear) begin
                state_next     = ACCUM;
                out_valid_next = 1'b0;
                idx_next       = '0;
                cmp_next       = CMP_EQ;
            end else begin
                case (state_reg)
                    ACCUM: begin
                        if (accept) begin
                            prev_next = in_data;
                            if (idx_reg == '0) begin
                                // prev from an earlier frame is ignored for the first sample
                                min_next  = in_data;
                                max_next  = in_data;
                                cmp_next  = CMP_EQ;
                                rise_next = '0;
                                fall_next = '0;
                            end else begin
                                cmp_next = {smp_lt, ~(smp_lt | smp_gt), smp_gt};
                                if (smp_gt) rise_next = rise_reg + CNT_W'(1);
                                if (smp_lt) fall_next = fall_reg + CNT_W'(1);
                                if (in_data < min_reg) min_next = in_data;
                                if (in_data > max_reg) max_next = in_data;
                            end
                            if (idx_reg == LAST_IDX) begin
                                idx_next       = '0;
                                state_next     = REPORT;
                                out_valid_next = 1'b1;
                            end else begin
                                idx_next = idx_reg + IDX_W'(1);
                            end
                        end
                    end
                    REPORT: begin
                        if (out_ready) begin
                            out_valid_next = 1'b0;
                            state_next     = ACCUM;
                        end
                    end
                    default: begin
                        state_next = ACCUM;
                    end
                endcase
            end
        end
    end

    assign cmp_lt    = cmp_reg[2];
    assign cmp_eq    = cmp_reg[1];
    assign cmp_gt    = cmp_reg[0];
    assign out_valid = out_valid_reg;
    assign frm_min   = min_reg;
    assign frm_max   = max_reg;
    assign rise_cnt  = rise_reg;
    assign fall_cnt  = fall_reg;

endmodule
